mix_columns_seq: RTL

MIX_COLUMNS_SEQ -- requirements
Module: mix_columns_seq

---
 rtl/aes_pkg.sv | 39 +++
 rtl/mix_column_unit.sv | 27 ++
 rtl/mix_columns_seq.sv | 89 ++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES MixColumns definitions: FSM states, field constants and column helpers.
package aes_pkg;

  localparam int BYTE_W   = 8;
  localparam int COL_W    = 32;
  localparam int NUM_COLS = 4;
  localparam int STATE_W  = 128;

  localparam logic [BYTE_W-1:0] GF_POLY = 8'h1b;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic [BYTE_W-1:0] xtime(input logic [BYTE_W-1:0] x);
    return {x[BYTE_W-2:0], 1'b0} ^ (x[BYTE_W-1] ? GF_POLY : 8'h00);
  endfunction

  // Column 0 sits in the most significant 32 bits, matching the byte-0-first layout.
  function automatic logic [COL_W-1:0] getColumn(input logic [STATE_W-1:0] st,
                                                 input logic [1:0] idx);
    logic [STATE_W-1:0] shifted;
    shifted = st << {idx, 5'b0};
    return shifted[STATE_W-1 -: COL_W];
  endfunction

  function automatic logic [STATE_W-1:0] putColumn(input logic [STATE_W-1:0] st,
                                                   input logic [1:0] idx,
                                                   input logic [COL_W-1:0] col);
    logic [STATE_W-1:0] mask;
    logic [STATE_W-1:0] placed;
    mask   = {{COL_W{1'b1}}, {(STATE_W-COL_W){1'b0}}} >> {idx, 5'b0};
    placed = {col, {(STATE_W-COL_W){1'b0}}} >> {idx, 5'b0};
    return (st & ~mask) | placed;
  endfunction

endpackage

// File: rtl/mix_column_unit.sv
// Forward MixColumns on a single 32-bit column; byte a0 is the most significant byte.
module mix_column_unit
  import aes_pkg::*;
(
  input  logic [COL_W-1:0] i_col,
  output logic [COL_W-1:0] o_col
);

  logic [BYTE_W-1:0] w_a0, w_a1, w_a2, w_a3;
  logic [BYTE_W-1:0] w_x0, w_x1, w_x2, w_x3;

  assign {w_a0, w_a1, w_a2, w_a3} = i_col;

  assign w_x0 = xtime(w_a0);
  assign w_x1 = xtime(w_a1);
  assign w_x2 = xtime(w_a2);
  assign w_x3 = xtime(w_a3);

  // 3x is folded in as 2x ^ x on the neighbouring byte.
  assign o_col = {
    w_x0 ^ (w_x1 ^ w_a1) ^ w_a2 ^ w_a3,
    w_a0 ^ w_x1 ^ (w_x2 ^ w_a2) ^ w_a3,
    w_a0 ^ w_a1 ^ w_x2 ^ (w_x3 ^ w_a3),
    (w_x0 ^ w_a0) ^ w_a1 ^ w_a2 ^ w_x3
  };

endmodule

// File: rtl/mix_columns_seq.sv
// Sequential AES MixColumns: captures a state, transforms COLS_PER_CYCLE columns per
// RUN cycle, then publishes the whole result at once with a one-cycle done_o pulse.
module mix_columns_seq
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic [STATE_W-1:0] state_i,
  output logic               ready_o,
  output logic               done_o,
  output logic [STATE_W-1:0] state_o
);

  localparam logic [1:0] STEP     = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LAST_COL = 2'(NUM_COLS - COLS_PER_CYCLE);

  state_e             r_state;
  logic [1:0]         r_colCnt;
  logic [STATE_W-1:0] r_in;
  logic [STATE_W-1:0] r_result;
  logic [STATE_W-1:0] r_stateOut;
  logic               r_done;

  logic [1:0]         w_colIdx [COLS_PER_CYCLE];
  logic [COL_W-1:0]   w_colIn  [COLS_PER_CYCLE];
  logic [COL_W-1:0]   w_colOut [COLS_PER_CYCLE];
  logic [STATE_W-1:0] w_nextResult;

  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_unit
    assign w_colIdx[g] = r_colCnt + 2'(g);
    assign w_colIn[g]  = getColumn(r_in, w_colIdx[g]);

    mix_column_unit u_unit (
      .i_col(w_colIn[g]),
      .o_col(w_colOut[g])
    );
  end

  always_comb begin
    w_nextResult = r_result;
    for (int g = 0; g < COLS_PER_CYCLE; g++) begin
      w_nextResult = putColumn(w_nextResult, w_colIdx[g], w_colOut[g]);
    end
  end

  // The counter wraps naturally in 2 bits; with four columns per cycle STEP is 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_colCnt   <= 2'd0;
      r_in       <= '0;
      r_result   <= '0;
      r_stateOut <= '0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start_i) begin
            r_in     <= state_i;
            r_colCnt <= 2'd0;
            r_state  <= RUN;
          end
        end
        RUN: begin
          r_result <= w_nextResult;
          r_colCnt <= r_colCnt + STEP;
          if (r_colCnt == LAST_COL) begin
            r_state <= DONE;
          end
        end
        DONE: begin
          r_done     <= 1'b1;
          r_stateOut <= r_result;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ready_o = (r_state == IDLE);
  assign done_o  = r_done;
  assign state_o = r_stateOut;

endmodule
